// File: rtl/dac_spi_multichannel.sv
// -----------------------------------------------------------------------------
// dac_spi_multichannel
//
// SPI serializer for multi-channel serial DACs (MCP4922 class). One accepted
// sample set loads every enabled channel as a {header, data} frame, MSB first,
// in ascending channel order. The DAC outputs are then committed together with
// an LDAC strobe.
//
// Build option:
//   DAC_SPI_LDAC_EN  defined   : after the last frame, ldac_n pulses low for
//                                2 half-periods, and done/s_ready follow it.
//                    undefined : there is no LDAC phase. ldac_n is held at 0, so
//                                each channel updates on its own cs_n rise, and
//                                done/s_ready assert at the end of the last gap.
//
// Parameters:
//   NUM_CH   channels per update (>=1)
//   DATA_W   sample bits per channel
//   HDR_W    header/command bits per channel
//   CLK_DIV  clk cycles per SCLK half-period T (>=1)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   s_valid  sample set valid
//   s_ready  idle, set accepted on s_valid && s_ready
//   s_data   channel k sample at [k*DATA_W +: DATA_W]
//   s_hdr    channel k header at [k*HDR_W +: HDR_W]
//   ch_en    channel k transmitted only when ch_en[k]
//   cs_n     chip select (active low)
//   sclk     serial clock, idles high; DAC samples on its rising edge
//   sdi      serial data, changes only on sclk falling edges
//   ldac_n   DAC latch strobe (active low)
//   done     one-cycle pulse at the end of an update
// -----------------------------------------------------------------------------
module dac_spi_multichannel #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 12,
  parameter int HDR_W   = 4,
  parameter int CLK_DIV = 25
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH*HDR_W-1:0]  s_hdr,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     cs_n,
  output logic                     sclk,
  output logic                     sdi,
  output logic                     ldac_n,
  output logic                     done
);

  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HC_W    = $clog2(2 * FRAME_W) + 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(2 * FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP,
    S_EMPTY
`ifdef DAC_SPI_LDAC_EN
    , S_LDAC
`endif
  } state_t;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m[k]) r = CH_W'(k);
    end
    return r;
  endfunction

  // {header, data} frame of channel k.
  function automatic logic [FRAME_W-1:0] frame_of(
    input logic [NUM_CH*DATA_W-1:0] d,
    input logic [NUM_CH*HDR_W-1:0]  h,
    input logic [CH_W-1:0]          k
  );
    return {h[int'(k)*HDR_W +: HDR_W], d[int'(k)*DATA_W +: DATA_W]};
  endfunction

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [HC_W-1:0]          half_q, half_d;
  logic [NUM_CH-1:0]        pend_q, pend_d;
  logic [FRAME_W-1:0]       shreg_q, shreg_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH*HDR_W-1:0]  hdr_q, hdr_d;
  logic                     cs_n_d, sclk_d, sdi_d, done_d, s_ready_d;
`ifdef DAC_SPI_LDAC_EN
  logic                     ldac_q, ldac_d;
`endif

  logic                     tick;
  logic [NUM_CH-1:0]        src_mask;
  logic [NUM_CH-1:0]        rest_mask;
  logic [FRAME_W-1:0]       load_frame;
  logic [FRAME_W-1:0]       shreg_shl;

  assign tick = (div_q == DIV_LAST);

  // The first frame is loaded straight from the inputs on the acceptance edge.
  // Later frames come from the latched copy and the pending-channel mask.
  assign src_mask   = (state_q == S_IDLE) ? ch_en : pend_q;
  assign rest_mask  = src_mask & (src_mask - NUM_CH'(1));
  assign load_frame = (state_q == S_IDLE)
                      ? frame_of(s_data, s_hdr, lowest_ch(ch_en))
                      : frame_of(data_q, hdr_q, lowest_ch(pend_q));
  assign shreg_shl  = shreg_q << 1;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    pend_d    = pend_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    hdr_d     = hdr_q;
    cs_n_d    = cs_n;
    sclk_d    = sclk;
    sdi_d     = sdi;
    done_d    = 1'b0;
    s_ready_d = s_ready;
`ifdef DAC_SPI_LDAC_EN
    ldac_d    = ldac_q;
`endif

    // The divider runs only while busy. Every phase lasts a whole number of
    // half-periods, so the counter is back at 0 whenever the block idles.
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready) begin
          data_d    = s_data;
          hdr_d     = s_hdr;
          div_d     = '0;
          s_ready_d = 1'b0;
          if (|ch_en) begin
            state_d = S_CS_SETUP;
            pend_d  = rest_mask;
            shreg_d = load_frame;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b1;
            sdi_d   = load_frame[FRAME_W-1];
          end else begin
            state_d = S_EMPTY;
            pend_d  = '0;
          end
        end
      end

      S_CS_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          half_d  = '0;
          sclk_d  = 1'b0;
        end
      end

      // Even half index: sclk low. Odd half index: sclk high. The next bit is
      // presented on each falling edge; the MSB is already on sdi from setup.
      S_SHIFT: begin
        if (tick) begin
          if (half_q == HALF_LAST) begin
            state_d = S_CS_HOLD;
          end else begin
            half_d = half_q + 1'b1;
            if (!half_q[0]) begin
              sclk_d = 1'b1;
            end else begin
              sclk_d  = 1'b0;
              shreg_d = shreg_shl;
              sdi_d   = shreg_shl[FRAME_W-1];
            end
          end
        end
      end

      S_CS_HOLD: begin
        if (tick) begin
          state_d = S_GAP;
          half_d  = '0;
          cs_n_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (tick) begin
          if (half_q == '0) begin
            half_d = HC_W'(1);
          end else if (|pend_q) begin
            state_d = S_CS_SETUP;
            pend_d  = rest_mask;
            shreg_d = load_frame;
            cs_n_d  = 1'b0;
            sdi_d   = load_frame[FRAME_W-1];
          end else begin
`ifdef DAC_SPI_LDAC_EN
            state_d = S_LDAC;
            half_d  = '0;
            ldac_d  = 1'b0;
`else
            state_d   = S_IDLE;
            done_d    = 1'b1;
            s_ready_d = 1'b1;
`endif
          end
        end
      end

`ifdef DAC_SPI_LDAC_EN
      S_LDAC: begin
        if (tick) begin
          if (half_q == '0) begin
            half_d = HC_W'(1);
          end else begin
            state_d   = S_IDLE;
            ldac_d    = 1'b1;
            done_d    = 1'b1;
            s_ready_d = 1'b1;
          end
        end
      end
`endif

      // Empty mask: nothing to send, but the update still takes one half-period.
      S_EMPTY: begin
        if (tick) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          s_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      pend_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      hdr_q   <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      sdi     <= 1'b0;
      done    <= 1'b0;
      s_ready <= 1'b1;
`ifdef DAC_SPI_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      sdi     <= sdi_d;
      done    <= done_d;
      s_ready <= s_ready_d;
`ifdef DAC_SPI_LDAC_EN
      ldac_q  <= ldac_d;
`endif
    end
  end

`ifdef DAC_SPI_LDAC_EN
  assign ldac_n = ldac_q;
`else
  // Latch input tied active: every channel updates on its own cs_n rise.
  assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_multichannel.sv
module tb_dac_spi_multichannel;

  localparam int CD     = 2;
  localparam int FW     = 16;
  localparam int PER_CH = 2 * FW + 4;
`ifdef DAC_SPI_LDAC_EN
  localparam bit LDAC_ON = 1'b1;
`else
  localparam bit LDAC_ON = 1'b0;
`endif
  localparam int LAT_11 = LDAC_ON ? 148 : 144;
  localparam int LAT_10 = LDAC_ON ? 76 : 72;
  localparam int LAT_00 = 2;
  localparam int LAT4_F = LDAC_ON ? 146 : 144;
  localparam int LAT4_A = LDAC_ON ? 74 : 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        s_valid, s_ready, cs_n, sclk, sdi, ldac_n, done;
  logic [23:0] s_data;
  logic [7:0]  s_hdr;
  logic [1:0]  ch_en;

  logic        s_valid2, s_ready2, cs_n2, sclk2, sdi2, ldac_n2, done2;
  logic [39:0] s_data2;
  logic [23:0] s_hdr2;
  logic [3:0]  ch_en2;

  dac_spi_multichannel #(.NUM_CH(2), .DATA_W(12), .HDR_W(4), .CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_hdr(s_hdr), .ch_en(ch_en), .cs_n(cs_n), .sclk(sclk),
    .sdi(sdi), .ldac_n(ldac_n), .done(done));

  dac_spi_multichannel #(.NUM_CH(4), .DATA_W(10), .HDR_W(6), .CLK_DIV(1)) dut4 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .s_hdr(s_hdr2), .ch_en(ch_en2), .cs_n(cs_n2), .sclk(sclk2),
    .sdi(sdi2), .ldac_n(ldac_n2), .done(done2));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model of the 2-channel DUT ----------------
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_a = 0, m_total = 0, m_E = 0;
  logic [23:0] m_data = '0;
  logic [7:0]  m_hdr = '0;
  logic [1:0]  m_en = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if ((!m_busy || (cyc - m_a >= m_total)) && s_valid) begin
        m_busy  <= 1'b1;
        m_a     <= cyc + 1;
        m_data  <= s_data;
        m_hdr   <= s_hdr;
        m_en    <= ch_en;
        m_E     <= $countones(ch_en);
        m_total <= ($countones(ch_en) == 0) ? CD
                   : (PER_CH * $countones(ch_en) + (LDAC_ON ? 2 : 0)) * CD;
      end else if (m_busy && (cyc - m_a >= m_total)) begin
        m_busy <= 1'b0;
      end
    end
  end

  function automatic int nth_ch(input logic [1:0] m, input int j);
    int seen;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      if (m[k]) begin
        if (seen == j) return k;
        seen++;
      end
    end
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    int t, u, c, r, h, k;
    logic [15:0] fr;
    logic e_cs, e_sclk, e_ldac, e_done, e_rdy, e_sdi;
    bit sdi_on;
    if (reset_n && chk_on) begin
      e_cs = 1'b1; e_sclk = 1'b1; e_ldac = LDAC_ON; e_done = 1'b0; e_rdy = 1'b1;
      e_sdi = 1'b0; sdi_on = 1'b0;
      if (m_busy) begin
        t = cyc - m_a;
        if (t < m_total) begin
          e_rdy = 1'b0;
          u = t / CD;
          if (u < PER_CH * m_E) begin
            c  = u / PER_CH;
            r  = u % PER_CH;
            k  = nth_ch(m_en, c);
            fr = {m_hdr[k*4 +: 4], m_data[k*12 +: 12]};
            if (r <= 2 * FW + 1) e_cs = 1'b0;
            if (r == 0) begin
              sdi_on = 1'b1;
              e_sdi  = fr[FW-1];
            end else if (r <= 2 * FW) begin
              h      = r - 1;
              e_sclk = (h % 2) == 1;
              sdi_on = 1'b1;
              e_sdi  = fr[FW - 1 - h / 2];
            end
          end else if (m_E > 0) begin
            e_ldac = 1'b0;
          end
        end else if (t == m_total) begin
          e_done = 1'b1;
        end
      end
      chk("ctrl {cs_n,sclk,ldac_n,done,s_ready}", {cs_n, sclk, ldac_n, done, s_ready},
          {e_cs, e_sclk, e_ldac, e_done, e_rdy});
      if (sdi_on) chk("sdi", sdi, e_sdi);
    end
  end

  // ---------------- frame capture on sclk rises ----------------
  logic [15:0] cap[$];
  logic [15:0] cap2[$];
  logic [15:0] wd = '0, wd2 = '0;
  logic p_cs = 1'b1, p_sclk = 1'b1, p_cs2 = 1'b1, p_sclk2 = 1'b1;
  int ldac_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_cs <= 1'b1; p_sclk <= 1'b1; p_cs2 <= 1'b1; p_sclk2 <= 1'b1;
    end else begin
      if (!p_sclk && sclk && !cs_n) wd <= {wd[14:0], sdi};
      if (!p_cs && cs_n) cap.push_back(wd);
      if (!p_sclk2 && sclk2 && !cs_n2) wd2 <= {wd2[14:0], sdi2};
      if (!p_cs2 && cs_n2) cap2.push_back(wd2);
      if (!ldac_n) ldac_cnt <= ldac_cnt + 1;
      p_cs <= cs_n; p_sclk <= sclk; p_cs2 <= cs_n2; p_sclk2 <= sclk2;
    end
  end

  function automatic logic [15:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 16'h0;
  endfunction

  function automatic logic [15:0] cap2_at(input int i);
    if (i < cap2.size()) return cap2[i];
    return 16'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic run_set(input logic [23:0] d, input logic [7:0] hd, input logic [1:0] en,
                         output int lat);
    @(negedge clk);
    s_data = d; s_hdr = hd; ch_en = en; s_valid = 1'b1;
    cap.delete();
    @(negedge clk);
    s_valid = 1'b0;
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_set2(input logic [39:0] d, input logic [23:0] hd, input logic [3:0] en,
                          output int lat);
    @(negedge clk);
    s_data2 = d; s_hdr2 = hd; ch_en2 = en; s_valid2 = 1'b1;
    cap2.delete();
    @(negedge clk);
    s_valid2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, n, l0;
    logic [39:0] d2;
    logic [23:0] h2;
    logic [3:0]  en2;

    reset_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_hdr = '0; ch_en = '0;
    s_valid2 = 1'b0; s_data2 = '0; s_hdr2 = '0; ch_en2 = '0;
    repeat (3) @(negedge clk);
    chk("reset {cs_n,sclk,sdi,ldac_n,done,s_ready}", {cs_n, sclk, sdi, ldac_n, done, s_ready},
        {1'b1, 1'b1, 1'b0, LDAC_ON, 1'b0, 1'b1});
    chk("reset4 {cs_n,sclk,sdi,ldac_n,done,s_ready}", {cs_n2, sclk2, sdi2, ldac_n2, done2, s_ready2},
        {1'b1, 1'b1, 1'b0, LDAC_ON, 1'b0, 1'b1});
    #2 reset_n = 1'b1;
    chk_on = 1'b1;

    // Four-channel instance, single-cycle half-period
    for (int i = 0; i < 2; i++) begin
      d2  = {8'($urandom), 32'($urandom)};
      h2  = 24'($urandom);
      en2 = (i == 0) ? 4'hF : 4'hA;
      run_set2(d2, h2, en2, lat);
      chk("ch4 latency", lat, (i == 0) ? LAT4_F : LAT4_A);
      chk("ch4 frame count", cap2.size(), $countones(en2));
      n = 0;
      for (int k = 0; k < 4; k++) begin
        if (en2[k]) begin
          chk("ch4 frame", cap2_at(n), {h2[k*6 +: 6], d2[k*10 +: 10]});
          n++;
        end
      end
    end

    // Both channels
    l0 = ldac_cnt;
    run_set(24'h5A5ABC, 8'hB3, 2'b11, lat);
    chk("both latency", lat, LAT_11);
    chk("both frame count", cap.size(), 2);
    chk("both frame0", cap_at(0), 16'h3ABC);
    chk("both frame1", cap_at(1), 16'hB5A5);
`ifdef DAC_SPI_LDAC_EN
    chk("ldac_n low clks", ldac_cnt - l0, 4);
`endif

    // Channel 1 only, then empty mask
    run_set(24'h5A5ABC, 8'hB3, 2'b10, lat);
    chk("ch1 latency", lat, LAT_10);
    chk("ch1 frame count", cap.size(), 1);
    chk("ch1 frame", cap_at(0), 16'hB5A5);
    run_set(24'h5A5ABC, 8'hB3, 2'b00, lat);
    chk("empty latency", lat, LAT_00);
    chk("empty frame count", cap.size(), 0);

    // Asynchronous reset during bit 7 of frame 0
    @(negedge clk);
    s_data = 24'h5A5ABC; s_hdr = 8'hB3; ch_en = 2'b11; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (31) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midframe reset {cs_n,sclk,sdi,ldac_n,done,s_ready}", {cs_n, sclk, sdi, ldac_n, done, s_ready},
           {1'b1, 1'b1, 1'b0, LDAC_ON, 1'b0, 1'b1});
    @(negedge clk);
    #2 reset_n = 1'b1;
    run_set(24'h123DEF, 8'h7C, 2'b11, lat);
    chk("post-reset latency", lat, LAT_11);
    chk("post-reset frame0", cap_at(0), 16'hCDEF);
    chk("post-reset frame1", cap_at(1), 16'h7123);

    // s_valid held high with inputs changing every cycle
    s_valid = 1'b1; ch_en = 2'b11;
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      s_data = 24'($urandom);
      s_hdr  = 8'($urandom);
    end
    s_valid = 1'b0;
    repeat (200) @(negedge clk);

    // Random traffic, including s_valid pulses while busy
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 15) == 0);
      s_data  = 24'($urandom);
      s_hdr   = 8'($urandom);
      ch_en   = 2'($urandom);
    end
    s_valid = 1'b0;
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
